dec_scan: RTL and testbench

- Registered, parametrised binary-to-one-hot decoder with an enable.
- Besides direct decoding, it can auto-scan its active output up or down at a programmable step rate, with wrap-around and a wrap pulse.
- Intended as the sequential successor to the combinational general decoder, for driving row/digit selects, mux strobes and round-robin channel enables from a single index register.

---
 rtl/dec_scan.sv | 70 +++++++
 tb/tb_dec_scan.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// dec_scan: registered binary-to-one-hot decoder with enable and a
// prescaled up/down auto-scan of the index, pulsing wrap on roll-over.
module dec_scan #(
    parameter int INPUT_WIDTH = 2,
    parameter int STEP_DIV    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         load,
    input  logic [INPUT_WIDTH-1:0]       w,
    output logic [0:(2**INPUT_WIDTH)-1]  y,
    output logic [INPUT_WIDTH-1:0]       idx,
    output logic                         wrap
);
    localparam int OUTPUT_WIDTH = 2**INPUT_WIDTH;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_UP     = 2'b01;
    localparam logic [1:0] M_DOWN   = 2'b10;

    logic [INPUT_WIDTH-1:0]  r_idx, w_idx_nx;
    logic [PW-1:0]           r_pre, w_pre_nx;
    logic [0:OUTPUT_WIDTH-1] r_y, w_y_nx;
    logic                    r_wrap, w_wrap_nx;
    logic                    w_step;

    assign w_step = (r_pre == PW'(STEP_DIV - 1));

    always_comb begin
        w_idx_nx  = r_idx;
        w_pre_nx  = r_pre;
        w_wrap_nx = 1'b0;
        if (load || mode == M_DIRECT) begin
            w_idx_nx = w;
            w_pre_nx = '0;
        end else if (mode == M_UP || mode == M_DOWN) begin
            w_pre_nx = w_step ? '0 : r_pre + PW'(1);
            if (w_step) begin
                w_idx_nx  = (mode == M_UP) ? r_idx + 1'b1 : r_idx - 1'b1;
                w_wrap_nx = (mode == M_UP) ? (r_idx == '1) : (r_idx == '0);
            end
        end
        for (int i = 0; i < OUTPUT_WIDTH; i++)
            w_y_nx[i] = (w_idx_nx == INPUT_WIDTH'(i));
    end

    // With en low the index and prescaler freeze while outputs go quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pre  <= '0;
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else if (!en) begin
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_idx  <= w_idx_nx;
            r_pre  <= w_pre_nx;
            r_y    <= w_y_nx;
            r_wrap <= w_wrap_nx;
        end
    end

    assign y    = r_y;
    assign idx  = r_idx;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: directed bench for dec_scan at STEP_DIV=1 and STEP_DIV=3,
// with a reference model feeding a scoreboard queue per instance.
module tb_dec_scan;
    logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'b00, w = 2'b00;
    logic [0:3] y_a, y_b;
    logic [1:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;
    int checks = 0, failures = 0;
    int m_idx [2] = '{0, 0};
    int m_pre [2] = '{0, 0};

    typedef struct packed {logic [0:3] y; logic [1:0] idx; logic wrap;} obs_t;
    obs_t sb_a [$];
    obs_t sb_b [$];

    always #5 clk = ~clk;

    dec_scan #(.INPUT_WIDTH(2), .STEP_DIV(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .w(w),
        .y(y_a), .idx(idx_a), .wrap(wrap_a));
    dec_scan #(.INPUT_WIDTH(2), .STEP_DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .w(w),
        .y(y_b), .idx(idx_b), .wrap(wrap_b));

    function automatic obs_t model(int k, int div);
        obs_t o;
        bit wr = 0;
        if (en) begin
            if (load || mode == 2'b00) begin
                m_idx[k] = int'(w);
                m_pre[k] = 0;
            end else if (mode != 2'b11) begin
                if (m_pre[k] == div - 1) begin
                    m_pre[k] = 0;
                    if (mode == 2'b01) begin
                        wr = (m_idx[k] == 3);
                        m_idx[k] = (m_idx[k] + 1) % 4;
                    end else begin
                        wr = (m_idx[k] == 0);
                        m_idx[k] = (m_idx[k] + 3) % 4;
                    end
                end else m_pre[k]++;
            end
        end
        o.idx  = 2'(m_idx[k]);
        o.wrap = wr;
        o.y    = en ? (4'b1000 >> m_idx[k]) : 4'b0000;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        obs_t e;
        sb_a.push_back(model(0, 1));
        sb_b.push_back(model(1, 3));
        @(posedge clk);
        #1;
        e = sb_a.pop_front();
        chk("a_y", 32'(y_a), 32'(e.y));
        chk("a_idx", 32'(idx_a), 32'(e.idx));
        chk("a_wrap", 32'(wrap_a), 32'(e.wrap));
        e = sb_b.pop_front();
        chk("b_y", 32'(y_b), 32'(e.y));
        chk("b_idx", 32'(idx_b), 32'(e.idx));
        chk("b_wrap", 32'(wrap_b), 32'(e.wrap));
    endtask

    task automatic lit_a(input string tag, input logic [1:0] i, input logic [0:3] yy, input logic wr);
        chk({tag, "_idx"}, 32'(idx_a), 32'(i));
        chk({tag, "_y"}, 32'(y_a), 32'(yy));
        chk({tag, "_wrap"}, 32'(wrap_a), 32'(wr));
    endtask

    task automatic lit_b(input string tag, input logic [1:0] i, input logic [0:3] yy, input logic wr);
        chk({tag, "_idx"}, 32'(idx_b), 32'(i));
        chk({tag, "_y"}, 32'(y_b), 32'(yy));
        chk({tag, "_wrap"}, 32'(wrap_b), 32'(wr));
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        lit_a("rst_a", 2'd0, 4'b0000, 1'b0);
        lit_b("rst_b", 2'd0, 4'b0000, 1'b0);
        m_idx = '{0, 0};
        m_pre = '{0, 0};
    endtask

    initial begin
        // Reset asserted between edges must act without a clock
        #2;
        async_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Direct decode, then disable
        en = 1'b1; mode = 2'b00;
        w = 2'd0; tick(); lit_a("d0", 2'd0, 4'b1000, 1'b0);
        w = 2'd1; tick(); lit_a("d1", 2'd1, 4'b0100, 1'b0);
        w = 2'd2; tick(); lit_a("d2", 2'd2, 4'b0010, 1'b0);
        w = 2'd3; tick(); lit_a("d3", 2'd3, 4'b0001, 1'b0);
        en = 1'b0; w = 2'd2; tick(); lit_a("dis", 2'd3, 4'b0000, 1'b0);

        // Scan up at full rate with wrap
        en = 1'b1; mode = 2'b01; load = 1'b1; w = 2'd2; tick(); lit_a("u0", 2'd2, 4'b0010, 1'b0);
        load = 1'b0;
        tick(); lit_a("u1", 2'd3, 4'b0001, 1'b0);
        tick(); lit_a("u2", 2'd0, 4'b1000, 1'b1);
        tick(); lit_a("u3", 2'd1, 4'b0100, 1'b0);

        // Prescaled scan down
        mode = 2'b10; load = 1'b1; w = 2'd0; tick(); lit_b("s0", 2'd0, 4'b1000, 1'b0);
        load = 1'b0;
        tick(); lit_b("s1", 2'd0, 4'b1000, 1'b0);
        tick(); lit_b("s2", 2'd0, 4'b1000, 1'b0);
        tick(); lit_b("s3", 2'd3, 4'b0001, 1'b1);
        tick(); tick(); lit_b("s5", 2'd3, 4'b0001, 1'b0);
        tick(); lit_b("s6", 2'd2, 4'b0010, 1'b0);

        // Load mid-prescale restarts the step count
        mode = 2'b01; load = 1'b1; w = 2'd0; tick();
        load = 1'b0; tick();
        load = 1'b1; w = 2'd1; tick(); lit_b("l0", 2'd1, 4'b0100, 1'b0);
        load = 1'b0;
        tick(); tick(); lit_b("l2", 2'd1, 4'b0100, 1'b0);
        tick(); lit_b("l3", 2'd2, 4'b0010, 1'b0);

        // Enable drop freezes scan, HOLD keeps index, then resume
        tick();
        en = 1'b0; load = 1'b1; w = 2'd3; mode = 2'b00;
        repeat (5) tick();
        lit_b("frz", 2'd2, 4'b0000, 1'b0);
        en = 1'b1; load = 1'b0; mode = 2'b01;
        repeat (4) tick();
        mode = 2'b11; repeat (3) tick();
        mode = 2'b10; repeat (7) tick();

        // Async reset mid-scan, then restart from a fresh state
        mode = 2'b01; load = 1'b1; w = 2'd3; tick(); lit_a("r0", 2'd3, 4'b0001, 1'b0);
        load = 1'b0;
        #1;
        async_reset();
        #4;
        rst_n = 1'b1;
        tick(); lit_a("r1", 2'd1, 4'b0100, 1'b0);
        tick(); lit_a("r2", 2'd2, 4'b0010, 1'b0);
        tick(); lit_a("r3", 2'd3, 4'b0001, 1'b0);
        tick(); lit_a("r4", 2'd0, 4'b1000, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
